mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WAIT_CYCLES, default 3, extra cycles the shared memory needs per access (legal 0..15).
REQ-002 Parameter AW, default 32, address width; data width is fixed at 32.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 if_req  input  1  IF stage requests an instruction fetch.
REQ-006 if_addr  input  AW  fetch address.
REQ-007 if_ready  output  1  one-cycle pulse: fetch done, if_rdata valid.
REQ-008 if_rdata  output  32  fetched instruction.
REQ-009 mem_rd / mem_wr  input  1 each  MEM stage read or write request.
REQ-010 mem_addr  input  AW  data address; mem_wdata  input  32  store data.
REQ-011 mem_ready  output  1  one-cycle pulse: data access done, mem_rdata valid on reads.
REQ-012 mem_rdata  output  32  load data.
REQ-013 if_stall / mem_stall  output  1 each  requester pending and not yet ready.
REQ-014 sram_en, sram_we  output  1 each  shared memory enable and write strobe.
REQ-015 sram_addr  output  AW; sram_wdata  output  32; sram_rdata  input  32.

Function
REQ-016 FSM states: IDLE, BUSY; cycle counter cnt, 4 bits; grant register gnt in {IF, MEM}.
REQ-017 IDLE, MEM request (mem_rd|mem_wr) present: gnt=MEM, latch addr/wdata/we, go BUSY, cnt=0.
REQ-018 IDLE, only if_req present: gnt=IF, latch if_addr, we=0, go BUSY, cnt=0.
REQ-019 Priority: MEM over IF, fixed; IF waits while MEM is pending.
REQ-020 BUSY: sram_en=1, sram_addr/sram_wdata/sram_we driven from latched values, held stable for WAIT_CYCLES+1 cycles.
REQ-021 BUSY with cnt==WAIT_CYCLES: assert granted requester's ready for that cycle, drive its rdata from sram_rdata, return to IDLE; otherwise cnt increments.
REQ-022 Latency: request sampled in IDLE at cycle t yields ready at cycle t+1+WAIT_CYCLES; next grant no earlier than t+2+WAIT_CYCLES.
REQ-023 Requesters hold request and operands stable until ready; inputs are ignored during BUSY.
REQ-024 mem_rd and mem_wr both high: treated as write; mem_rdata undefined.
REQ-025 Request withdrawn during BUSY (flush): access still completes; ready still pulses and the requester ignores it.
REQ-026 if_rdata and mem_rdata are registered and hold last value between ready pulses.
REQ-027 if_stall = if_req & ~if_ready; mem_stall = (mem_rd|mem_wr) & ~mem_ready; both combinational.
REQ-028 IDLE: sram_en=0, sram_we=0.

Reset
REQ-029 rst=1 at a clock edge: state IDLE, cnt=0, gnt=IF, if_ready=mem_ready=0, if_rdata=mem_rdata=0, sram_en=sram_we=0 from the next cycle.
REQ-030 Reset mid-BUSY aborts the access with no ready pulse; a write in progress leaves memory content unspecified.

Structure
REQ-031 State encoding (IDLE/BUSY) and grant encoding (IF/MEM) belong in a shared package alongside the pipeline's other enumerations.
REQ-032 One sub-module: wait_counter (load, enable, terminal-count flag at WAIT_CYCLES).

Verification
REQ-033 WAIT_CYCLES=3, if_req at t=0, addr 0x40, memory word 0xE3A01005 -> if_ready at t=4 only, if_rdata=0xE3A01005, if_stall high t=0..3.
REQ-034 if_req and mem_rd (addr 0x100, data 0x0000002A) together at t=0 -> mem_ready at t=4 with 0x2A; IF granted t=5, if_ready at t=9.
REQ-035 mem_wr addr 0x200 data 0xDEADBEEF, then mem_rd 0x200 -> sram_we high exactly 4 cycles; read returns 0xDEADBEEF.
REQ-036 WAIT_CYCLES=0, back-to-back if_req -> if_ready every 2nd cycle, sram_en high 1 cycle per access.
REQ-037 rst asserted at t=2 of a MEM read -> no mem_ready; sram_en=0 at t=3; a fresh request after reset completes normally.
REQ-038 if_req dropped at t=1 of a fetch -> sram_en stays high through t=4; if_ready pulses at t=4; FSM back in IDLE at t=5.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the fetch/data memory arbiter and its helpers.
package mem_arbiter_pkg;

    typedef logic [0:0] state_t;
    typedef logic [0:0] gnt_t;

    localparam state_t ST_IDLE = 1'b0;
    localparam state_t ST_BUSY = 1'b1;

    localparam gnt_t GNT_IF  = 1'b0;
    localparam gnt_t GNT_MEM = 1'b1;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;

endpackage

// File: rtl/mem_arbiter_wait_counter.sv
// Access-length counter: cleared on load, counts while enabled, flags WAIT_CYCLES.
module wait_counter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned TC_VAL = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic tc
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = '0;
        else if (en)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign tc = (cnt_q == CNT_W'(TC_VAL));

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto one single-ported memory with a fixed
// access length of WAIT_CYCLES+1 cycles; the data port always wins.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 3,
    parameter int unsigned AW          = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [AW-1:0]     if_addr,
    output logic              if_ready,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [AW-1:0]     mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              mem_ready,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              if_stall,
    output logic              mem_stall,
    output logic              sram_en,
    output logic              sram_we,
    output logic [AW-1:0]     sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    state_t            state_q, state_d;
    gnt_t              gnt_q, gnt_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;

    logic mem_req, busy, tc, done;

    assign mem_req = mem_rd | mem_wr;
    assign busy    = (state_q == ST_BUSY);
    assign done    = busy & tc;

    wait_counter #(.TC_VAL(WAIT_CYCLES)) u_wait_counter (
        .clk  (clk),
        .rst  (rst),
        .load (~busy),
        .en   (busy & ~tc),
        .tc   (tc)
    );

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        if (!busy) begin
            if (mem_req) begin
                state_d = ST_BUSY;
                gnt_d   = GNT_MEM;
                addr_d  = mem_addr;
                wdata_d = mem_wdata;
                we_d    = mem_wr; // rd+wr together is a write
            end else if (if_req) begin
                state_d = ST_BUSY;
                gnt_d   = GNT_IF;
                addr_d  = if_addr;
                we_d    = 1'b0;
            end
        end else if (tc) begin
            state_d = ST_IDLE;
        end
    end

    assign if_ready  = done & (gnt_q == GNT_IF);
    assign mem_ready = done & (gnt_q == GNT_MEM);

    // Read data is bypassed on the ready cycle, then held in the register.
    always_comb begin
        if_rdata_d  = if_ready  ? sram_rdata : if_rdata_q;
        mem_rdata_d = mem_ready ? sram_rdata : mem_rdata_q;
    end

    assign if_rdata  = if_rdata_d;
    assign mem_rdata = mem_rdata_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            gnt_q       <= GNT_IF;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    assign sram_en    = busy;
    assign sram_we    = busy & we_q;
    assign sram_addr  = addr_q;
    assign sram_wdata = wdata_q;

    assign if_stall  = if_req & ~if_ready;
    assign mem_stall = mem_req & ~mem_ready;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: WAIT_CYCLES=3 instance plus a WAIT_CYCLES=0 instance.
module tb_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        if_req, if_ready, mem_rd, mem_wr, mem_ready, if_stall, mem_stall;
    logic [31:0] if_addr, if_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        sram_en, sram_we;
    logic [31:0] sram_addr, sram_wdata, sram_rdata;

    logic        if_req0, if_ready0, mem_ready0, if_stall0, mem_stall0, sram_en0, sram_we0;
    logic [31:0] if_addr0, if_rdata0, mem_rdata0, sram_addr0, sram_wdata0, sram_rdata0;
    logic        zero_b;
    logic [31:0] zero_w;

    mem_arbiter #(.WAIT_CYCLES(3), .AW(32)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .if_stall(if_stall), .mem_stall(mem_stall),
        .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    mem_arbiter #(.WAIT_CYCLES(0), .AW(32)) dut0 (
        .clk(clk), .rst(rst),
        .if_req(if_req0), .if_addr(if_addr0), .if_ready(if_ready0), .if_rdata(if_rdata0),
        .mem_rd(zero_b), .mem_wr(zero_b), .mem_addr(zero_w), .mem_wdata(zero_w),
        .mem_ready(mem_ready0), .mem_rdata(mem_rdata0),
        .if_stall(if_stall0), .mem_stall(mem_stall0),
        .sram_en(sram_en0), .sram_we(sram_we0), .sram_addr(sram_addr0),
        .sram_wdata(sram_wdata0), .sram_rdata(sram_rdata0)
    );

    // Asynchronous-read, synchronous-write memory models, one per instance.
    logic [31:0] mem3 [0:1023];
    logic [31:0] mem0 [0:1023];
    logic        ld_en, ld_sel;
    logic [9:0]  ld_a;
    logic [31:0] ld_d;

    always @(posedge clk) begin
        if (ld_en && !ld_sel) mem3[ld_a] <= ld_d;
        else if (sram_en && sram_we) mem3[sram_addr[11:2]] <= sram_wdata;
        if (ld_en && ld_sel) mem0[ld_a] <= ld_d;
        else if (sram_en0 && sram_we0) mem0[sram_addr0[11:2]] <= sram_wdata0;
    end

    assign sram_rdata  = mem3[sram_addr[11:2]];
    assign sram_rdata0 = mem0[sram_addr0[11:2]];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic ld(input logic s, input logic [31:0] a, input logic [31:0] d);
        ld_sel = s;
        ld_a   = a[11:2];
        ld_d   = d;
        ld_en  = 1'b1;
        nxt();
        ld_en  = 1'b0;
    endtask

    int we_cnt;

    initial begin
        rst = 1'b1; zero_b = 1'b0; zero_w = '0;
        if_req = 0; if_addr = 0; mem_rd = 0; mem_wr = 0; mem_addr = 0; mem_wdata = 0;
        if_req0 = 0; if_addr0 = 0;
        ld_en = 0; ld_sel = 0; ld_a = 0; ld_d = 0;
        nxt();
        ld(1'b0, 32'h40,  32'hE3A01005);
        ld(1'b0, 32'h100, 32'h0000002A);
        ld(1'b1, 32'h40,  32'h12345678);
        rst = 1'b0;
        smp();
        chk("rst_if_ready",  if_ready,  0);
        chk("rst_mem_ready", mem_ready, 0);
        chk("rst_if_rdata",  if_rdata,  0);
        chk("rst_mem_rdata", mem_rdata, 0);
        chk("rst_sram_en",   sram_en,   0);
        chk("rst_sram_we",   sram_we,   0);

        // Single fetch, 4-cycle latency
        for (int t = 0; t <= 5; t++) begin
            nxt();
            if (t == 0) begin if_req = 1; if_addr = 32'h40; end
            if (t == 5) if_req = 0;
            smp();
            chk($sformatf("fetch_ready@%0d", t), if_ready, (t == 4));
            chk($sformatf("fetch_stall@%0d", t), if_stall, (t <= 3));
            chk($sformatf("fetch_en@%0d", t),    sram_en,  (t >= 1 && t <= 4));
            if (t >= 4) chk($sformatf("fetch_rdata@%0d", t), if_rdata, 32'hE3A01005);
        end

        // Simultaneous requests: data port first, fetch follows
        for (int t = 0; t <= 10; t++) begin
            nxt();
            if (t == 0) begin
                if_req = 1; if_addr = 32'h40; mem_rd = 1; mem_addr = 32'h100;
            end
            if (t == 5)  mem_rd = 0;
            if (t == 10) if_req = 0;
            smp();
            chk($sformatf("prio_mem_ready@%0d", t), mem_ready, (t == 4));
            chk($sformatf("prio_if_ready@%0d", t),  if_ready,  (t == 9));
            chk($sformatf("prio_mem_stall@%0d", t), mem_stall, (t < 4));
            chk($sformatf("prio_if_stall@%0d", t),  if_stall,  (t < 9));
            if (t == 4) chk("prio_mem_rdata", mem_rdata, 32'h2A);
            if (t == 5) chk("prio_gap_en", sram_en, 0);
            if (t == 9) chk("prio_if_rdata", if_rdata, 32'hE3A01005);
        end

        // Write then read back
        we_cnt = 0;
        for (int t = 0; t <= 5; t++) begin
            nxt();
            if (t == 0) begin mem_wr = 1; mem_addr = 32'h200; mem_wdata = 32'hDEADBEEF; end
            if (t == 5) mem_wr = 0;
            smp();
            if (sram_we) we_cnt++;
            if (t == 4) chk("wr_ready", mem_ready, 1);
        end
        chk("wr_we_cycles", we_cnt, 4);
        for (int t = 0; t <= 5; t++) begin
            nxt();
            if (t == 0) mem_rd = 1;
            if (t == 5) mem_rd = 0;
            smp();
            chk($sformatf("rd_ready@%0d", t), mem_ready, (t == 4));
            if (t == 4) chk("rd_rdata", mem_rdata, 32'hDEADBEEF);
        end

        // Reset in the middle of a data read
        for (int t = 0; t <= 6; t++) begin
            nxt();
            if (t == 0) begin mem_rd = 1; mem_addr = 32'h100; end
            if (t == 2) begin rst = 1; mem_rd = 0; end
            if (t == 3) rst = 0;
            smp();
            chk($sformatf("abort_ready@%0d", t), mem_ready, 0);
            if (t == 2) chk("abort_en_t2", sram_en, 1);
            if (t == 3) chk("abort_en_t3", sram_en, 0);
            if (t == 3) chk("abort_rdata_clr", mem_rdata, 0);
        end
        for (int t = 0; t <= 5; t++) begin
            nxt();
            if (t == 0) begin mem_rd = 1; mem_addr = 32'h40; end
            if (t == 5) mem_rd = 0;
            smp();
            chk($sformatf("post_rst_ready@%0d", t), mem_ready, (t == 4));
            if (t == 4) chk("post_rst_rdata", mem_rdata, 32'hE3A01005);
        end

        // Fetch withdrawn during the access still completes
        for (int t = 0; t <= 5; t++) begin
            nxt();
            if (t == 0) begin if_req = 1; if_addr = 32'h40; end
            if (t == 1) if_req = 0;
            smp();
            chk($sformatf("flush_en@%0d", t),    sram_en,  (t >= 1 && t <= 4));
            chk($sformatf("flush_ready@%0d", t), if_ready, (t == 4));
            if (t >= 1) chk($sformatf("flush_stall@%0d", t), if_stall, 0);
        end

        // Zero wait cycles: back-to-back fetches every other cycle
        for (int t = 0; t <= 7; t++) begin
            nxt();
            if (t == 0) begin if_req0 = 1; if_addr0 = 32'h40; end
            smp();
            chk($sformatf("w0_ready@%0d", t), if_ready0, (t % 2 == 1));
            chk($sformatf("w0_en@%0d", t),    sram_en0,  (t % 2 == 1));
            if (t == 1) chk("w0_rdata", if_rdata0, 32'h12345678);
        end
        nxt();
        if_req0 = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
